hps_mmio_bridge: RTL and testbench

HPS_MMIO_BRIDGE -- requirements
Module: hps_mmio_bridge

---
 rtl/hps_mmio_bridge_pkg.sv | 49 ++++
 rtl/hps_mmio_irq_ctrl.sv | 47 ++++
 rtl/hps_mmio_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_hps_mmio_bridge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_mmio_bridge_pkg.sv
// hps_mmio_bridge_pkg: register map, channel block layout, ID and interrupt
// field offsets shared by the MMIO bridge and its interrupt controller.
package hps_mmio_bridge_pkg;

  // Global register byte offsets
  localparam logic [7:0] ADDR_ID             = 8'h00;
  localparam logic [7:0] ADDR_RX_THRESHOLD   = 8'h04;
  localparam logic [7:0] ADDR_COMP_THRESHOLD = 8'h08;
  localparam logic [7:0] ADDR_GUARD_INTERVAL = 8'h0C;
  localparam logic [7:0] ADDR_MEM_ADDR       = 8'h10;
  localparam logic [7:0] ADDR_END_ADDRESS    = 8'h14;
  localparam logic [7:0] ADDR_LED            = 8'h18;
  localparam logic [7:0] ADDR_KEY            = 8'h1C;
  localparam logic [7:0] ADDR_IRQ_STATUS     = 8'h20;
  localparam logic [7:0] ADDR_IRQ_ENABLE     = 8'h24;
  localparam logic [7:0] ADDR_NAVIG_START    = 8'h28;

  // Channel c block starts at CH_BASE + c*CH_STRIDE
  localparam logic [7:0] CH_BASE   = 8'h40;
  localparam logic [7:0] CH_STRIDE = 8'h10;

  // Word offset inside a channel block (address[3:2])
  typedef enum logic [1:0] {
    CH_TX_DATA = 2'd0,
    CH_RX_DATA = 2'd1,
    CH_STATUS  = 2'd2,
    CH_CTRL    = 2'd3
  } ch_reg_e;

  // ID register: fixed tag in the upper bits, channel count in the low bits
  localparam logic [31:0] ID_BASE = 32'h4850_0000;

  // IRQ_STATUS field offsets: source events, TX overflow, RX underflow
  localparam int IRQ_SRC_LSB = 0;
  localparam int IRQ_OVF_LSB = 8;
  localparam int IRQ_UNF_LSB = 16;

  // Reset values of the threshold registers
  localparam logic [31:0] RST_RX_THRESHOLD   = 32'd600;
  localparam logic [31:0] RST_COMP_THRESHOLD = 32'd6;

  // Upper address nibble that selects channel c's block
  function automatic logic [3:0] ch_block(input int c);
    logic [7:0] a;
    a = CH_BASE + 8'(c) * CH_STRIDE;
    return a[7:4];
  endfunction

endpackage

// File: rtl/hps_mmio_irq_ctrl.sv
// hps_mmio_irq_ctrl: sticky interrupt status with write-1-to-clear, an
// enable mask and a registered interrupt request. A set event arriving in
// the same cycle as a clear of the same bit wins.
module hps_mmio_irq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] set_vec,
  input  logic        wr_status,
  input  logic        wr_enable,
  input  logic [31:0] wdata,
  output logic [31:0] status,
  output logic [31:0] enable,
  output logic        irq
);

  logic [31:0] status_q, status_d;
  logic [31:0] enable_q, enable_d;
  logic        irq_q;

  // Next-state: clear requested bits first, then OR in new events
  always_comb begin
    status_d = status_q;
    enable_d = enable_q;
    if (wr_status) status_d = status_d & ~wdata;
    status_d = status_d | set_vec;
    if (wr_enable) enable_d = wdata;
  end

  // irq is registered from the next-state so it rises on the same edge the
  // causing status bit is captured, i.e. one cycle after the cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      enable_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      enable_q <= enable_d;
      irq_q    <= |(status_d & enable_d);
    end
  end

  assign status = status_q;
  assign enable = enable_q;
  assign irq    = irq_q;

endmodule

// File: rtl/hps_mmio_bridge.sv
// hps_mmio_bridge: Avalon-MM slave exposing global control registers and
// NCH TX/RX FIFO channel blocks. Reads have one cycle latency and readdata
// holds until the next read. All strobes toward the FIFOs and timers are
// registered single-cycle pulses.
// Optional feature macro: HPS_MMIO_BRIDGE_IRQ_EN enables the interrupt
// status/enable registers and the irq output; otherwise irq is tied low
// and those registers read as zero.
// Bus handshake: an access occurs in any cycle with chipselect high and a
// strobe; write_en wins when both strobes are high; there is no wait state.
module hps_mmio_bridge
  import hps_mmio_bridge_pkg::*;
#(
  parameter int NCH = 2,
  parameter int DW  = 8,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        address,
  input  logic              chipselect,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NCH*DW-1:0] tx_data,
  output logic [NCH-1:0]    tx_wren,
  input  logic [NCH-1:0]    tx_full,
  input  logic [NCH*CW-1:0] tx_level,
  input  logic [NCH-1:0]    tx_ready,
  output logic [NCH-1:0]    tx_start,
  input  logic [NCH*DW-1:0] rx_data,
  output logic [NCH-1:0]    rx_rden,
  input  logic [NCH*CW-1:0] rx_level,
  input  logic [NCH-1:0]    irq_src,
  output logic              irq,
  output logic              navig_timer_start,
  output logic [7:0]        led,
  input  logic [1:0]        key,
  output logic [31:0]       rx_threshold,
  output logic [31:0]       comp_threshold,
  output logic [31:0]       guard_interval,
  output logic [31:0]       mem_addr,
  input  logic [31:0]       end_address
);

  logic              wr_acc, rd_acc;
  logic [NCH-1:0]    ch_hit;
  logic [NCH-1:0]    push_d, ovf, pop_d, unf, start_d;
  logic [31:0]       rd_mux;
  logic [31:0]       irq_set;
  logic [31:0]       irq_status, irq_enable;

  logic [31:0]       readdata_q;
  logic [NCH*DW-1:0] tx_data_q;
  logic [NCH-1:0]    tx_wren_q, tx_start_q, rx_rden_q;
  logic              navig_q;
  logic [7:0]        led_q;
  logic [31:0]       rx_thr_q, comp_thr_q, guard_q, mem_addr_q;
  logic [1:0]        key_s1, key_s2;

  assign wr_acc = chipselect & write_en;
  assign rd_acc = chipselect & read_en & ~write_en;

  // Address decode, channel side effects and read-data mux
  always_comb begin
    ch_hit  = '0;
    push_d  = '0;
    ovf     = '0;
    pop_d   = '0;
    unf     = '0;
    start_d = '0;
    rd_mux  = '0;
    case (address)
      ADDR_ID:             rd_mux = ID_BASE | 32'(NCH);
      ADDR_RX_THRESHOLD:   rd_mux = rx_thr_q;
      ADDR_COMP_THRESHOLD: rd_mux = comp_thr_q;
      ADDR_GUARD_INTERVAL: rd_mux = guard_q;
      ADDR_MEM_ADDR:       rd_mux = mem_addr_q;
      ADDR_END_ADDRESS:    rd_mux = end_address;
      ADDR_LED:            rd_mux = {24'd0, led_q};
      ADDR_KEY:            rd_mux = {30'd0, key_s2};
      ADDR_IRQ_STATUS:     rd_mux = irq_status;
      ADDR_IRQ_ENABLE:     rd_mux = irq_enable;
      default:             rd_mux = '0;
    endcase
    for (int c = 0; c < NCH; c++) begin
      ch_hit[c] = (address[1:0] == 2'b00) && (address[7:4] == ch_block(c));
      if (ch_hit[c]) begin
        case (address[3:2])
          CH_TX_DATA: begin
            if (wr_acc) begin
              if (tx_full[c]) ovf[c] = 1'b1;
              else            push_d[c] = 1'b1;
            end
          end
          CH_RX_DATA: begin
            if (rx_level[c*CW +: CW] != '0) begin
              rd_mux[DW-1:0] = rx_data[c*DW +: DW];
              if (rd_acc) pop_d[c] = 1'b1;
            end else if (rd_acc) begin
              unf[c] = 1'b1;
            end
          end
          CH_STATUS: begin
            rd_mux[CW-1:0]  = rx_level[c*CW +: CW];
            rd_mux[16 +: CW] = tx_level[c*CW +: CW];
            rd_mux[15]      = tx_ready[c];
          end
          CH_CTRL: begin
            if (wr_acc && writedata[0] && tx_ready[c]) start_d[c] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Interrupt event vector: sources, overflows and underflows per channel
  always_comb begin
    irq_set = '0;
    for (int c = 0; c < NCH; c++) begin
      irq_set[IRQ_SRC_LSB + c] = irq_src[c];
      irq_set[IRQ_OVF_LSB + c] = ovf[c];
      irq_set[IRQ_UNF_LSB + c] = unf[c];
    end
  end

  // Global registers, read data, push data and registered pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
      tx_data_q  <= '0;
      tx_wren_q  <= '0;
      tx_start_q <= '0;
      rx_rden_q  <= '0;
      navig_q    <= 1'b0;
      led_q      <= '0;
      rx_thr_q   <= RST_RX_THRESHOLD;
      comp_thr_q <= RST_COMP_THRESHOLD;
      guard_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      if (rd_acc) readdata_q <= rd_mux;
      tx_wren_q  <= push_d;
      tx_start_q <= start_d;
      rx_rden_q  <= pop_d;
      navig_q    <= wr_acc && (address == ADDR_NAVIG_START);
      for (int c = 0; c < NCH; c++) begin
        if (push_d[c]) tx_data_q[c*DW +: DW] <= writedata[DW-1:0];
      end
      if (wr_acc) begin
        case (address)
          ADDR_RX_THRESHOLD:   rx_thr_q   <= writedata;
          ADDR_COMP_THRESHOLD: comp_thr_q <= writedata;
          ADDR_GUARD_INTERVAL: guard_q    <= writedata;
          ADDR_MEM_ADDR:       mem_addr_q <= writedata;
          ADDR_LED:            led_q      <= writedata[7:0];
          default: ;
        endcase
      end
    end
  end

  // Two-flop synchroniser for the asynchronous pushbuttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

`ifdef HPS_MMIO_BRIDGE_IRQ_EN
  hps_mmio_irq_ctrl u_irq_ctrl (
    .clk       (clk),
    .rst       (reset),
    .set_vec   (irq_set),
    .wr_status (wr_acc && (address == ADDR_IRQ_STATUS)),
    .wr_enable (wr_acc && (address == ADDR_IRQ_ENABLE)),
    .wdata     (writedata),
    .status    (irq_status),
    .enable    (irq_enable),
    .irq       (irq)
  );
`else
  logic unused_irq_set;
  assign unused_irq_set = ^irq_set;
  assign irq_status     = '0;
  assign irq_enable     = '0;
  assign irq            = 1'b0;
`endif

  assign readdata          = readdata_q;
  assign tx_data           = tx_data_q;
  assign tx_wren           = tx_wren_q;
  assign tx_start          = tx_start_q;
  assign rx_rden           = rx_rden_q;
  assign navig_timer_start = navig_q;
  assign led               = led_q;
  assign rx_threshold      = rx_thr_q;
  assign comp_threshold    = comp_thr_q;
  assign guard_interval    = guard_q;
  assign mem_addr          = mem_addr_q;

endmodule

// File: tb/tb_hps_mmio_bridge.sv
// tb_hps_mmio_bridge: directed test of the MMIO bridge with default
// parameters (NCH=2, DW=8, CW=8). Expectations for interrupt registers
// follow HPS_MMIO_BRIDGE_IRQ_EN as defined for the build.
module tb_hps_mmio_bridge;

  localparam int NCH = 2;
  localparam int DW  = 8;
  localparam int CW  = 8;
`ifdef HPS_MMIO_BRIDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              read_en = 1'b0;
  logic              write_en = 1'b0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [NCH*DW-1:0] tx_data;
  logic [NCH-1:0]    tx_wren;
  logic [NCH-1:0]    tx_full = '0;
  logic [NCH*CW-1:0] tx_level = '0;
  logic [NCH-1:0]    tx_ready = '0;
  logic [NCH-1:0]    tx_start;
  logic [NCH*DW-1:0] rx_data = '0;
  logic [NCH-1:0]    rx_rden;
  logic [NCH*CW-1:0] rx_level = '0;
  logic [NCH-1:0]    irq_src = '0;
  logic              irq;
  logic              navig_timer_start;
  logic [7:0]        led;
  logic [1:0]        key = '0;
  logic [31:0]       rx_threshold, comp_threshold, guard_interval, mem_addr;
  logic [31:0]       end_address = '0;

  int n_checks = 0;
  int n_fail   = 0;

  hps_mmio_bridge #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .address           (address),
    .chipselect        (chipselect),
    .read_en           (read_en),
    .write_en          (write_en),
    .writedata         (writedata),
    .readdata          (readdata),
    .tx_data           (tx_data),
    .tx_wren           (tx_wren),
    .tx_full           (tx_full),
    .tx_level          (tx_level),
    .tx_ready          (tx_ready),
    .tx_start          (tx_start),
    .rx_data           (rx_data),
    .rx_rden           (rx_rden),
    .rx_level          (rx_level),
    .irq_src           (irq_src),
    .irq               (irq),
    .navig_timer_start (navig_timer_start),
    .led               (led),
    .key               (key),
    .rx_threshold      (rx_threshold),
    .comp_threshold    (comp_threshold),
    .guard_interval    (guard_interval),
    .mem_addr          (mem_addr),
    .end_address       (end_address)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle write; returns at the negedge after the capturing edge
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_en = 1'b1; read_en = 1'b0;
    address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_en = 1'b0;
  endtask

  // Single-cycle read; readdata is valid when this returns
  task automatic bus_read(input logic [7:0] a);
    @(negedge clk);
    chipselect = 1'b1; read_en = 1'b1; write_en = 1'b0;
    address = a;
    @(negedge clk);
    chipselect = 1'b0; read_en = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_led", {24'd0, led}, 32'd0);
    check("rst_rx_thr", rx_threshold, 32'd600);
    check("rst_comp_thr", comp_threshold, 32'd6);
    check("rst_guard", guard_interval, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_pulses", {26'd0, tx_wren, tx_start, rx_rden}, 32'd0);
    reset = 1'b0;

    // Reset values read over the bus with one-cycle latency
    bus_read(8'h04);
    check("rd_rx_thr", readdata, 32'd600);
    bus_read(8'h08);
    check("rd_comp_thr", readdata, 32'd6);
    bus_read(8'h00);
    check("rd_id", readdata, 32'h4850_0002);

    // RW and RO globals
    bus_write(8'h18, 32'h0000_1234);
    check("led_out", {24'd0, led}, 32'h34);
    bus_read(8'h18);
    check("rd_led", readdata, 32'h34);
    bus_write(8'h0C, 32'hCAFE_0001);
    check("guard_out", guard_interval, 32'hCAFE_0001);
    bus_write(8'h10, 32'h1000_0040);
    bus_read(8'h10);
    check("rd_mem_addr", readdata, 32'h1000_0040);
    bus_write(8'h00, 32'hFFFF_FFFF);
    bus_read(8'h00);
    check("id_ro", readdata, 32'h4850_0002);
    end_address = 32'hDEAD_BEEF;
    bus_read(8'h14);
    check("rd_end_addr", readdata, 32'hDEAD_BEEF);
    // Readdata holds while idle
    @(negedge clk);
    check("rd_hold", readdata, 32'hDEAD_BEEF);

    // Both strobes high counts as a write
    @(negedge clk);
    chipselect = 1'b1; write_en = 1'b1; read_en = 1'b1;
    address = 8'h18; writedata = 32'h55;
    @(negedge clk);
    chipselect = 1'b0; write_en = 1'b0; read_en = 1'b0;
    check("rw_is_write_led", {24'd0, led}, 32'h55);
    check("rw_no_read", readdata, 32'hDEAD_BEEF);

    // Key synchroniser
    key = 2'b10;
    repeat (3) @(negedge clk);
    bus_read(8'h1C);
    check("rd_key", readdata, 32'd2);

    // TX push on channel 1
    tx_full = 2'b00;
    bus_write(8'h50, 32'h0000_00A5);
    check("tx_wren_pulse", {30'd0, tx_wren}, 32'h2);
    check("tx_data_ch1", {24'd0, tx_data[15:8]}, 32'hA5);
    @(negedge clk);
    check("tx_wren_single", {30'd0, tx_wren}, 32'h0);
    // TX overflow
    tx_full = 2'b10;
    bus_write(8'h50, 32'h0000_005A);
    check("tx_ovf_no_pulse", {30'd0, tx_wren}, 32'h0);
    check("tx_ovf_data_kept", {24'd0, tx_data[15:8]}, 32'hA5);
    tx_full = 2'b00;
    bus_read(8'h20);
    check("irq_ovf_bit9", readdata, IRQ_ON ? 32'h0000_0200 : 32'h0);

    // RX pop on channel 0
    rx_level = {8'd0, 8'd3};
    rx_data  = {8'h77, 8'h3C};
    bus_read(8'h44);
    check("rx_pop_data", readdata, 32'h3C);
    check("rx_rden_pulse", {30'd0, rx_rden}, 32'h1);
    @(negedge clk);
    check("rx_rden_single", {30'd0, rx_rden}, 32'h0);
    check("rx_data_hold", readdata, 32'h3C);
    // Channel status
    tx_level = {8'd9, 8'd4}; tx_ready = 2'b01;
    bus_read(8'h48);
    check("ch0_status", readdata, 32'h0004_8003);
    tx_ready = 2'b00;
    // RX underflow
    rx_level = '0;
    bus_read(8'h44);
    check("rx_unf_data", readdata, 32'h0);
    check("rx_unf_no_pulse", {30'd0, rx_rden}, 32'h0);
    bus_read(8'h20);
    check("irq_unf_bit16", readdata, IRQ_ON ? 32'h0001_0200 : 32'h0);
    bus_write(8'h20, 32'h0001_0200);
    bus_read(8'h20);
    check("irq_w1c_clear", readdata, 32'h0);

    // Interrupt path
    bus_write(8'h24, 32'h1);
    bus_read(8'h24);
    check("rd_irq_enable", readdata, IRQ_ON ? 32'h1 : 32'h0);
    check("irq_idle", {31'd0, irq}, 32'd0);
    @(negedge clk);
    irq_src = 2'b01;
    @(negedge clk);
    irq_src = 2'b00;
    check("irq_assert", {31'd0, irq}, {31'd0, IRQ_ON});
    // Set and W1C in the same cycle: set wins
    @(negedge clk);
    irq_src = 2'b01;
    chipselect = 1'b1; write_en = 1'b1; address = 8'h20; writedata = 32'h1;
    @(negedge clk);
    irq_src = 2'b00;
    chipselect = 1'b0; write_en = 1'b0;
    check("irq_set_wins", {31'd0, irq}, {31'd0, IRQ_ON});
    bus_read(8'h20);
    check("irq_status_kept", readdata, IRQ_ON ? 32'h1 : 32'h0);
    bus_write(8'h20, 32'h1);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Channel bounds and write-only reads
    bus_read(8'h00);
    bus_read(8'h60);
    check("rd_ch2_zero", readdata, 32'h0);
    bus_read(8'h00);
    bus_read(8'h40);
    check("rd_tx_data_wo", readdata, 32'h0);
    bus_read(8'h00);
    bus_read(8'h2C);
    check("rd_unmapped", readdata, 32'h0);

    // CTRL start gated by tx_ready
    tx_ready = 2'b00;
    bus_write(8'h4C, 32'h1);
    check("start_not_ready", {30'd0, tx_start}, 32'h0);
    tx_ready = 2'b01;
    bus_write(8'h4C, 32'h1);
    check("start_pulse", {30'd0, tx_start}, 32'h1);
    @(negedge clk);
    check("start_single", {30'd0, tx_start}, 32'h0);
    bus_write(8'h4C, 32'h0);
    check("start_bit0_clear", {30'd0, tx_start}, 32'h0);

    // Navigation timer pulse
    bus_write(8'h28, 32'h0);
    check("navig_pulse", {31'd0, navig_timer_start}, 32'd1);
    @(negedge clk);
    check("navig_single", {31'd0, navig_timer_start}, 32'd0);

    // Reset during an access aborts it
    @(negedge clk);
    tx_full = 2'b00;
    chipselect = 1'b1; write_en = 1'b1; address = 8'h50; writedata = 32'h11;
    reset = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write_en = 1'b0;
    reset = 1'b0;
    check("abort_no_wren", {30'd0, tx_wren}, 32'h0);
    @(negedge clk);
    check("abort_no_wren_after", {30'd0, tx_wren}, 32'h0);
    check("abort_tx_data_rst", {16'd0, tx_data}, 32'h0);
    check("abort_led_rst", {24'd0, led}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
